// File: rtl/locker_access_ctrl.sv
// Locker access controller: code-entry gating, timed latch release, ajar watch and lockout.
// Optional audible alarm in AJAR/LOCKOUT is built only when LOCKER_ALARM_EN is defined.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a code; entry enabled, wrong codes counted
//   OPEN    | latch released for UNLOCK_CYC cycles
//   AJAR    | release window over but door still open; wait for it to close
//   LOCKOUT | MAX_FAIL wrong codes seen; entry blocked for LOCK_CYC cycles
module locker_access_ctrl #(
    parameter int MAX_FAIL   = 3,
    parameter int UNLOCK_CYC = 16,
    parameter int LOCK_CYC   = 32
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       code_ok,
    input  logic       code_bad,
    input  logic       door_closed,
    output logic       entry_en,
    output logic       unlock,
    output logic       lockout,
    output logic       buzzer,
    output logic [1:0] fail_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_AJAR    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] UNLOCK_LOAD = 8'(UNLOCK_CYC - 1);
    localparam logic [7:0] LOCK_LOAD   = 8'(LOCK_CYC - 1);
    localparam logic [2:0] FAIL_LIMIT  = 3'(MAX_FAIL);

    if (MAX_FAIL < 1 || MAX_FAIL > 3) begin : g_bad_max_fail
        $error("locker_access_ctrl: MAX_FAIL must be 1..3");
    end
    if (UNLOCK_CYC < 1 || UNLOCK_CYC > 255) begin : g_bad_unlock_cyc
        $error("locker_access_ctrl: UNLOCK_CYC must be 1..255");
    end
    if (LOCK_CYC < 1 || LOCK_CYC > 255) begin : g_bad_lock_cyc
        $error("locker_access_ctrl: LOCK_CYC must be 1..255");
    end

    state_t     cur_st;
    state_t     nxt_st;
    logic [7:0] timer;
    logic [7:0] nxt_timer;
    logic [1:0] fail_q;
    logic [1:0] nxt_fail;
    logic [2:0] fail_inc;
    logic       entry_en_q;
    logic       unlock_q;
    logic       lockout_q;

    assign fail_inc = {1'b0, fail_q} + 3'd1;

    always_comb begin
        nxt_st    = cur_st;
        nxt_timer = timer;
        nxt_fail  = fail_q;
        case (cur_st)
            ST_IDLE: begin
                // code_ok wins when both pulses land in the same cycle
                if (code_ok) begin
                    nxt_fail  = 2'd0;
                    nxt_timer = UNLOCK_LOAD;
                    nxt_st    = ST_OPEN;
                end else if (code_bad) begin
                    if (fail_inc >= FAIL_LIMIT) begin
                        nxt_fail  = FAIL_LIMIT[1:0];
                        nxt_timer = LOCK_LOAD;
                        nxt_st    = ST_LOCKOUT;
                    end else begin
                        nxt_fail = fail_inc[1:0];
                    end
                end
            end
            ST_OPEN: begin
                if (timer == 8'd0) begin
                    nxt_st = door_closed ? ST_IDLE : ST_AJAR;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            ST_AJAR: begin
                if (door_closed) begin
                    nxt_st = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer == 8'd0) begin
                    nxt_fail = 2'd0;
                    nxt_st   = ST_IDLE;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock) begin
        if (clear) begin
            cur_st     <= ST_IDLE;
            timer      <= 8'd0;
            fail_q     <= 2'd0;
            entry_en_q <= 1'b1;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            timer      <= nxt_timer;
            fail_q     <= nxt_fail;
            entry_en_q <= (nxt_st == ST_IDLE);
            unlock_q   <= (nxt_st == ST_OPEN);
            lockout_q  <= (nxt_st == ST_LOCKOUT);
        end
    end

`ifdef LOCKER_ALARM_EN
    logic buzzer_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= (nxt_st == ST_AJAR) || (nxt_st == ST_LOCKOUT);
        end
    end

    assign buzzer = buzzer_q;
`else
    assign buzzer = 1'b0;
`endif

    assign entry_en = entry_en_q;
    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;
    assign state    = cur_st;

endmodule

// File: tb/tb_locker_access_ctrl.sv
// Directed self-checking bench for locker_access_ctrl at default parameters.
module tb_locker_access_ctrl;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       code_ok = 1'b0;
    logic       code_bad = 1'b0;
    logic       door_closed = 1'b1;
    logic       entry_en;
    logic       unlock;
    logic       lockout;
    logic       buzzer;
    logic [1:0] fail_cnt;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LOCKER_ALARM_EN
    localparam logic ALARM = 1'b1;
`else
    localparam logic ALARM = 1'b0;
`endif

    locker_access_ctrl dut (
        .clock       (clock),
        .clear       (clear),
        .code_ok     (code_ok),
        .code_bad    (code_bad),
        .door_closed (door_closed),
        .entry_en    (entry_en),
        .unlock      (unlock),
        .lockout     (lockout),
        .buzzer      (buzzer),
        .fail_cnt    (fail_cnt),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // state, entry_en, unlock, lockout, buzzer, fail_cnt in one go
    task automatic check_all(input string tag, input logic [1:0] st, input logic en,
                             input logic ul, input logic lo, input logic bz, input logic [1:0] fc);
        check({tag, ".state"},    8'(state),    8'(st));
        check({tag, ".entry_en"}, 8'(entry_en), 8'(en));
        check({tag, ".unlock"},   8'(unlock),   8'(ul));
        check({tag, ".lockout"},  8'(lockout),  8'(lo));
        check({tag, ".buzzer"},   8'(buzzer),   8'(bz));
        check({tag, ".fail_cnt"}, 8'(fail_cnt), 8'(fc));
    endtask

    initial begin
        #2;
        // reset
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_all("reset", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // correct code, door shut: 16 cycles OPEN then IDLE
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        check_all("open_c1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 2; i <= 16; i++) begin
            step();
            check("open_hold.state", 8'(state), 8'd1);
            check("open_hold.unlock", 8'(unlock), 8'd1);
        end
        step();
        check_all("open_end", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // three wrong codes two cycles apart -> 32 cycles LOCKOUT
        code_bad = 1'b1;
        step();
        code_bad = 1'b0;
        check_all("bad1", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        step();
        code_bad = 1'b1;
        step();
        code_bad = 1'b0;
        check_all("bad2", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        step();
        code_bad = 1'b1;
        step();
        code_bad = 1'b0;
        check_all("lock_c1", 2'd3, 1'b0, 1'b0, 1'b1, ALARM, 2'd3);
        for (int i = 2; i <= 32; i++) begin
            // codes during lockout must be ignored
            code_ok  = (i == 5);
            code_bad = (i == 7);
            step();
            check("lock_hold.state", 8'(state), 8'd3);
            check("lock_hold.lockout", 8'(lockout), 8'd1);
            check("lock_hold.fail_cnt", 8'(fail_cnt), 8'd3);
        end
        code_ok  = 1'b0;
        code_bad = 1'b0;
        step();
        check_all("lock_end", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // two wrong, then right code clears count; wrong code in OPEN ignored
        code_bad = 1'b1;
        step();
        step();
        code_bad = 1'b0;
        check("two_bad.fail_cnt", 8'(fail_cnt), 8'd2);
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        check_all("ok_after_bad", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        code_bad = 1'b1;
        step();
        code_bad = 1'b0;
        check_all("bad_in_open", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (14) step();
        check("open2_last.state", 8'(state), 8'd1);
        step();
        check_all("open2_end", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // door left open at expiry -> AJAR until shut
        door_closed = 1'b0;
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        repeat (15) step();
        check("ajar_pre.state", 8'(state), 8'd1);
        step();
        check_all("ajar", 2'd2, 1'b0, 1'b0, 1'b0, ALARM, 2'd0);
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        step();
        check_all("ajar_hold", 2'd2, 1'b0, 1'b0, 1'b0, ALARM, 2'd0);
        door_closed = 1'b1;
        step();
        check_all("ajar_close", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // clear at cycle 10 of LOCKOUT
        code_bad = 1'b1;
        repeat (3) step();
        code_bad = 1'b0;
        check("lock2_c1.state", 8'(state), 8'd3);
        repeat (9) step();
        check("lock2_c10.state", 8'(state), 8'd3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_all("clear_lock", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // clear mid-OPEN, with a code pulse competing
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        repeat (4) step();
        check("open3_c5.state", 8'(state), 8'd1);
        clear   = 1'b1;
        code_ok = 1'b1;
        step();
        clear   = 1'b0;
        code_ok = 1'b0;
        check_all("clear_open", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // simultaneous ok and bad in IDLE -> treated as ok
        code_ok  = 1'b1;
        code_bad = 1'b1;
        step();
        code_ok  = 1'b0;
        code_bad = 1'b0;
        check_all("both", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
